instruction_line_fetcher: RTL and testbench
===========================================

# instruction_line_fetcher

Fills one instruction-cache block from a word-wide instruction ROM using consecutive single-word reads. It sits directly downstream of the instruction cache. To the cache it presents a block-wide `inst_data` / `inst_busy` port. To the ROM it drives a word-wide request/acknowledge handshake. A block is `2**L2_BLOCK_SIZE` bytes and a ROM word is `2**L2_WORD_SIZE` bytes. A fill therefore takes `BEATS = 2**(L2_BLOCK_SIZE-L2_WORD_SIZE)` ROM reads.

## Interface
- `L2_BLOCK_SIZE`, default 6: log2 of block size in bytes. Must match the cache.
- `L2_ADDR_SIZE`, default 5: log2 of address width in bits.
- `L2_WORD_SIZE`, default 2: log2 of ROM word size in bytes. Requires `L2_WORD_SIZE < L2_BLOCK_SIZE`.
- `clock`, input, 1: the single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `inst_enable`, input, 1: fill request from the cache.
- `inst_addr`, input, `2**L2_ADDR_SIZE`: requested byte address. Any alignment.
- `inst_data`, output, `2**(L2_BLOCK_SIZE+3)`: assembled block.
- `inst_busy`, output, 1: high while a fill is accepted or in progress.
- `rom_enable`, output, 1: ROM read request.
- `rom_addr`, output, `2**L2_ADDR_SIZE`: word-aligned ROM byte address.
- `rom_data`, input, `2**(L2_WORD_SIZE+3)`: ROM read data. Valid only when `rom_ack` is high.
- `rom_ack`, input, 1: one-cycle completion pulse for the current beat.

## Operation
- **Registers**
  - `base`: block-aligned address.
  - `beat`: counter, `L2_BLOCK_SIZE-L2_WORD_SIZE` bits wide.
  - `line`: assembly register that drives `inst_data`.
  - `rom_addr`: registered.
  - `state`: one of IDLE or FILL.
- **Reset values** (reset low at a rising edge): state=IDLE, `rom_enable`=0, `rom_addr`=0, `inst_data`=0, `beat`=0. `inst_busy`=0 as long as `inst_enable` is low.
- **IDLE**
  - `rom_enable`=0.
  - If `inst_enable`=1:
    - `base` ← `inst_addr` with its low `L2_BLOCK_SIZE` bits cleared.
    - `rom_addr` ← the same value.
    - `beat` ← 0.
    - Next state is FILL.
- **FILL**
  - `rom_enable`=1. `rom_addr` = `base + (beat << L2_WORD_SIZE)`, held stable until `rom_ack`.
  - Each cycle with `rom_ack`=1 writes `rom_data` into `line` word slot `beat`. The slot is bits `[(beat+1)*W-1 : beat*W]`, where W is the word width in bits. Word 0 goes to the LSBs (little-endian), matching the cache's block layout.
  - After an ack on a beat other than the last, `beat` increments and `rom_addr` advances by `2**L2_WORD_SIZE`.
  - An ack on beat `BEATS-1` returns the block to IDLE and clears `beat` to 0.
  - Any number of wait cycles (`rom_ack`=0) is allowed. `rom_enable` stays high across them.
- **`inst_busy`** = (state==FILL) OR (state==IDLE AND `inst_enable`).
  - The cache sees busy in the same cycle it raises enable.
- **Address arithmetic**
  - `base + offset` never carries out of the block, because `base` is block-aligned.
  - Address wrap-around at the top of memory is not possible within a fill.
- **`inst_enable` during FILL** is ignored. `base` is not re-latched and no request is queued. The cache holds enable until busy falls; the next fill is then accepted from IDLE.
- **`rom_ack` in IDLE** is ignored, and `line` is not written.
- **`inst_data` validity**
  - Valid only in cycles where `inst_busy`=0 following a completed fill.
  - During a fill it is partially overwritten.
- **Reset mid-fill**: the fill is aborted and all registers take their reset values. `rom_enable` drops in the cycle after the reset edge.

## Timing
- The request is sampled in cycle 0 (IDLE, `inst_enable`=1), with `inst_busy` high combinationally.
- FILL starts in cycle 1.
- **Zero-wait ROM** (ack in every FILL cycle):
  - Beat k completes in cycle 1+k.
  - The last ack is in cycle `BEATS`.
  - `inst_busy`=0 and the complete `inst_data` appear in cycle `BEATS+1`. That is cycle 17 for the defaults.
- **General latency**: `BEATS + W_total + 1` cycles from request to `inst_busy` low, where `W_total` is the total number of wait cycles.
- **Back-to-back fills**: a request held high in the first IDLE cycle after a fill starts FILL on the next cycle.
  - That IDLE cycle shows `inst_busy`=1 (combinational term).
  - The cache must therefore sample data on busy falling with enable low, or in the cycle it deasserts enable.

## Test plan
- **Reset**: hold `reset`=0 for 2 cycles with `inst_enable`=1 → `rom_enable`=0, `rom_addr`=0, `inst_data`=0. `inst_busy` equals `inst_enable`.
- **Zero-wait fill** of `inst_addr`=0x00000044, with ROM word = address:
  - `rom_addr` steps 0x40, 0x44, … 0x7C.
  - `inst_busy` falls in cycle 17.
  - `inst_data[31:0]`=0x40 and `inst_data[511:480]`=0x7C.
- **Wait states**: ROM acks every third cycle → `rom_addr` is held for 3 cycles per beat, `inst_busy` falls in cycle 49, and data is identical to the zero-wait case.
- **Enable during fill**: change `inst_addr` to 0x100 in cycle 5 of a fill at 0x40 → `rom_addr` stays in 0x40–0x7C and the completed block is from 0x40.
- **Reset mid-fill**: drive `reset`=0 at beat 7 → next cycle state=IDLE, `rom_enable`=0, `inst_data`=0. A new request at 0x80 then fills 0x80–0xBC correctly.
- **Back-to-back**: fill 0x00 then immediately 0xC0 → the second fill starts on the cycle after the first-fill IDLE cycle, with `rom_addr`=0xC0 and no beat lost or duplicated.

Source files
------------

// File: rtl/instruction_line_fetcher.sv
// rtl/instruction_line_fetcher.sv - fills one instruction-cache block from a word-wide ROM
module instruction_line_fetcher #(
    parameter int L2_BLOCK_SIZE = 6,
    parameter int L2_ADDR_SIZE  = 5,
    parameter int L2_WORD_SIZE  = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                inst_enable,
    input  logic [2**L2_ADDR_SIZE-1:0]          inst_addr,
    output logic [2**(L2_BLOCK_SIZE+3)-1:0]     inst_data,
    output logic                                inst_busy,
    output logic                                rom_enable,
    output logic [2**L2_ADDR_SIZE-1:0]          rom_addr,
    input  logic [2**(L2_WORD_SIZE+3)-1:0]      rom_data,
    input  logic                                rom_ack
);

    localparam int ADDR_W = 2**L2_ADDR_SIZE;
    localparam int WORD_W = 2**(L2_WORD_SIZE+3);
    localparam int BEAT_W = L2_BLOCK_SIZE - L2_WORD_SIZE;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   beat_inc;
    logic                last_beat;
    logic [ADDR_W-1:0]   next_addr;
    logic [ADDR_W-1:0]   req_base;
    logic                unused_addr_bits;

    // base is block-aligned, so adding the word offset can never carry out of the block
    assign beat_inc         = beat + BEAT_W'(1);
    assign last_beat        = (beat == {BEAT_W{1'b1}});
    assign next_addr        = base + (ADDR_W'(beat_inc) << L2_WORD_SIZE);
    assign req_base         = {inst_addr[ADDR_W-1:L2_BLOCK_SIZE], {L2_BLOCK_SIZE{1'b0}}};
    assign unused_addr_bits = ^inst_addr[L2_BLOCK_SIZE-1:0];

    // Combinational term lets the cache see busy in the same cycle it raises enable
    assign inst_busy = (state == FILL) || ((state == IDLE) && inst_enable);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            base       <= '0;
            beat       <= '0;
            rom_enable <= 1'b0;
            rom_addr   <= '0;
            inst_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rom_enable <= 1'b0;
                    if (inst_enable) begin
                        base       <= req_base;
                        rom_addr   <= req_base;
                        beat       <= '0;
                        rom_enable <= 1'b1;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    // Enable and address changes are ignored until the block is complete
                    if (rom_ack) begin
                        inst_data[beat*WORD_W +: WORD_W] <= rom_data;
                        if (last_beat) begin
                            beat       <= '0;
                            rom_enable <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            beat     <= beat_inc;
                            rom_addr <= next_addr;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    rom_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_line_fetcher.sv
// tb/tb_instruction_line_fetcher.sv - self-checking bench for instruction_line_fetcher
module tb_instruction_line_fetcher;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 512;
    localparam int WORD_W = 32;
    localparam int BEATS  = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              inst_enable = 1'b0;
    logic [ADDR_W-1:0] inst_addr = '0;
    logic [LINE_W-1:0] inst_data;
    logic              inst_busy;
    logic              rom_enable;
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_data = '0;
    logic              rom_ack = 1'b0;

    always #5 clock = ~clock;

    instruction_line_fetcher dut (
        .clock       (clock),
        .reset       (reset),
        .inst_enable (inst_enable),
        .inst_addr   (inst_addr),
        .inst_data   (inst_data),
        .inst_busy   (inst_busy),
        .rom_enable  (rom_enable),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .rom_ack     (rom_ack)
    );

    int checks = 0;
    int errors = 0;
    logic [ADDR_W-1:0] exp_q[$];

    typedef struct {
        string             name;
        logic [ADDR_W-1:0] addr;
        int                period;
        int                chg_cycle;
        logic [ADDR_W-1:0] chg_addr;
        int                hold_until;
        int                exp_cycles;
        logic [ADDR_W-1:0] exp_base;
    } fill_vec_t;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] block_of(input logic [ADDR_W-1:0] base);
        logic [LINE_W-1:0] r;
        r = '0;
        for (int k = 0; k < BEATS; k++)
            r[k*WORD_W +: WORD_W] = base + ADDR_W'(k * 4);
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Entered in the request cycle (cycle 0); returns in the first IDLE cycle after the fill
    task automatic run_fill(input fill_vec_t v);
        int cyc;
        logic [ADDR_W-1:0] cur;
        inst_enable = 1'b1;
        inst_addr   = v.addr;
        rom_ack     = 1'b0;
        exp_q.delete();
        for (int k = 0; k < BEATS; k++)
            exp_q.push_back(v.exp_base + ADDR_W'(k * 4));
        #1 chk({v.name, " busy_c0"}, inst_busy, 1'b1);
        cyc = 0;
        while (1) begin
            next_cycle();
            cyc++;
            rom_ack = 1'b0;
            if (cyc > 400) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: got %0d cycles required %0d", v.name, cyc, v.exp_cycles);
                break;
            end
            if (!rom_enable) break;
            if (cyc == v.chg_cycle) inst_addr = v.chg_addr;
            if (cyc >= v.hold_until) inst_enable = 1'b0;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s extra_beat: got rom_addr %0h required no request", v.name, rom_addr);
                break;
            end
            rom_ack  = ((cyc % v.period) == 0);
            rom_data = rom_addr;
            if (rom_ack) cur = exp_q.pop_front();
            else         cur = exp_q[0];
            chk({v.name, " rom_addr"}, rom_addr, cur);
            #1 chk({v.name, " busy_fill"}, inst_busy, 1'b1);
        end
        rom_ack = 1'b0;
        chk({v.name, " cycles"}, cyc, v.exp_cycles);
        chk({v.name, " beats_left"}, exp_q.size(), 0);
        chk({v.name, " data"}, inst_data, block_of(v.exp_base));
        #1 chk({v.name, " busy_end"}, inst_busy, inst_enable);
    endtask

    fill_vec_t vecs[6];

    initial begin
        vecs[0] = '{"zero_wait",   32'h0000_0044, 1, 0,  32'h0,        1,    17, 32'h0000_0040};
        vecs[1] = '{"wait3",       32'h0000_0044, 3, 0,  32'h0,        1,    49, 32'h0000_0040};
        vecs[2] = '{"en_in_fill",  32'h0000_0040, 1, 5,  32'h0000_0100, 10,  17, 32'h0000_0040};
        vecs[3] = '{"top_of_mem",  32'hFFFF_FFC8, 2, 0,  32'h0,        1,    33, 32'hFFFF_FFC0};
        vecs[4] = '{"b2b_first",   32'h0000_0000, 1, 16, 32'h0000_00C0, 1000, 17, 32'h0000_0000};
        vecs[5] = '{"b2b_second",  32'h0000_00C0, 1, 0,  32'h0,        1,    17, 32'h0000_00C0};

        reset       = 1'b0;
        inst_enable = 1'b1;
        inst_addr   = 32'h44;
        repeat (2) next_cycle();
        chk("reset rom_enable", rom_enable, 1'b0);
        chk("reset rom_addr", rom_addr, 32'h0);
        chk("reset inst_data", inst_data, '0);
        chk("reset busy_en_high", inst_busy, 1'b1);
        inst_enable = 1'b0;
        #1 chk("reset busy_en_low", inst_busy, 1'b0);
        reset = 1'b1;
        next_cycle();

        for (int i = 0; i < 6; i++)
            run_fill(vecs[i]);

        inst_enable = 1'b0;
        next_cycle();
        inst_enable = 1'b1;
        inst_addr   = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            inst_enable = 1'b0;
            rom_ack     = 1'b1;
            rom_data    = rom_addr;
            if (c == 8) begin
                chk("midreset beat7_addr", rom_addr, 32'h1C);
                reset = 1'b0;
            end
        end
        next_cycle();
        rom_ack = 1'b0;
        chk("midreset rom_enable", rom_enable, 1'b0);
        chk("midreset rom_addr", rom_addr, 32'h0);
        chk("midreset inst_data", inst_data, '0);
        #1 chk("midreset busy", inst_busy, 1'b0);
        reset = 1'b1;
        next_cycle();
        run_fill('{"after_reset", 32'h0000_0080, 1, 0, 32'h0, 1, 17, 32'h0000_0080});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
